// File: rtl/fetch_ctl.sv
// fifo: generic synchronous FIFO with a single-cycle clear, used as the fetch return buffer
// latency: a word pushed in cycle N is visible at the head in cycle N+1
// backpressure: pop_vld drops when empty; the producer must respect count (overflow is asserted)
module fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    push_vld,
   input  logic [W-1:0]            push_dat,
   input  logic                    pop_rdy,
   output logic                    pop_vld,
   output logic [W-1:0]            pop_dat,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          full;

   // clear wins over both push and pop in the same cycle
   assign push    = push_vld & ~clr;
   assign pop     = pop_rdy & pop_vld & ~clr;
   assign pop_vld = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_dat = mem[rd_ptr];

   // pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   // storage is not reset; only entries below count are ever observed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   // a push into a full buffer without a simultaneous pop would lose a word
   assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// fetch_ctl: owns the PC, issues in-order word fetches and buffers returned words with their PC
// latency: imem_req_* is combinational from state; response in cycle N shows on if_valid in N+1
// backpressure: requests stop once in-flight + buffered reaches DEPTH; if_ready=0 holds the buffer
module fetch_ctl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_sel,
   input  logic [31:0] alu_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        flush,
   output logic        misalign
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   pc;
   logic [31:0]   pc_nxt;
   logic [31:0]   rsp_pc;
   logic [31:0]   rsp_pc_nxt;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] drop_cnt_nxt;
   logic [CW-1:0] buf_count;
   logic [CW:0]   in_use;
   logic          credit;
   logic          redirect;
   logic          req_fire;
   logic          rsp_keep;
   logic          flush_nxt;
   logic          misalign_nxt;
   logic [31:0]   target_al;
   logic [63:0]   buf_head;
   logic          unused_target_bit0;

   // bit 0 of the target is meaningless for word fetch; bit 1 only raises misalign
   assign target_al          = {alu_target[31:2], 2'b00};
   assign unused_target_bit0 = alu_target[0];

   // every word either in flight or sitting in the buffer holds one slot
   assign in_use        = {1'b0, outstanding} + {1'b0, buf_count};
   assign credit        = (in_use < (CW+1)'(DEPTH));
   assign imem_req_addr = pc;

   // next-state, request handshake, response routing and redirect handling
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      rsp_pc_nxt      = rsp_pc;
      outstanding_nxt = outstanding;
      drop_cnt_nxt    = drop_cnt;
      imem_req_valid  = 1'b0;
      req_fire        = 1'b0;
      redirect        = 1'b0;
      rsp_keep        = 1'b0;
      flush_nxt       = 1'b0;
      misalign_nxt    = 1'b0;
      case (state)
         BOOT: begin
            // one idle cycle after reset; redirects are ignored and nothing is requested
            state_nxt = RUN;
         end
         default: begin
            redirect        = pc_sel;
            // never request during a redirect cycle: the address would be stale
            imem_req_valid  = credit & ~pc_sel;
            req_fire        = imem_req_valid & imem_req_ready;
            outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
               pc_nxt       = target_al;
               rsp_pc_nxt   = target_al;
               // everything still in flight after this edge belongs to the old path
               drop_cnt_nxt = outstanding_nxt;
               flush_nxt    = 1'b1;
               misalign_nxt = alu_target[1];
            end else begin
               if (req_fire) pc_nxt = pc + 32'd4;
               if (imem_rsp_valid) begin
                  if (drop_cnt != '0) begin
                     drop_cnt_nxt = drop_cnt - CW'(1);
                  end else begin
                     rsp_keep   = 1'b1;
                     rsp_pc_nxt = rsp_pc + 32'd4;
                  end
               end
            end
            // RUN never holds a nonzero drop count, so this covers RUN->DRAIN on a
            // redirect with work in flight and DRAIN->RUN once the last stale word is gone
            state_nxt = (drop_cnt_nxt != '0) ? DRAIN : RUN;
         end
      endcase
   end

   // architectural state and registered pulse outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         flush       <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         rsp_pc      <= rsp_pc_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_cnt_nxt;
         flush       <= flush_nxt;
         misalign    <= misalign_nxt;
      end
   end

   // return buffer: {pc, instr}; a redirect squashes it and masks any same-cycle pop
   fifo #(
      .W     (64),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (redirect),
      .push_vld (rsp_keep),
      .push_dat ({rsp_pc, imem_rsp_data}),
      .pop_rdy  (if_ready),
      .pop_vld  (if_valid),
      .pop_dat  (buf_head),
      .count    (buf_count)
   );

   assign if_pc    = buf_head[63:32];
   assign if_instr = buf_head[31:0];
endmodule

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: scoreboard bench for fetch_ctl with a one-cycle in-order memory model
// expected fetch addresses and decoded words are produced by a reference model of the PC/credit
// every cycle checks request valid/address, if_valid, flush, misalign and popped entries
module tb_fetch_ctl;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_sel;
   logic [31:0] alu_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic        misalign;

   fetch_ctl #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_sel         (pc_sel),
      .alu_target     (alu_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .flush          (flush),
      .misalign       (misalign)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mem_q [$];   // model addresses accepted by memory, oldest first
   logic [63:0] exp_q [$];   // expected {pc, instr} in the decode buffer
   logic [31:0] m_pc;
   int          m_drop;
   logic        m_boot;
   logic        m_flush;
   logic        m_mis;
   int          req_seen;
   logic        watch_first;
   logic [31:0] first_pc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   // one clock cycle: entered and left at posedge+1
   task automatic cycle(input logic sel, input logic [31:0] tgt, input logic dec_rdy,
                        input logic mem_rdy, input logic rsp_en);
      logic        redir;
      logic        exp_req;
      logic        has_rsp;
      logic [31:0] a;
      logic [63:0] e;
      has_rsp        = rsp_en && (mem_q.size() != 0);
      pc_sel         = sel;
      alu_target     = tgt;
      if_ready       = dec_rdy;
      imem_req_ready = mem_rdy;
      imem_rsp_valid = has_rsp;
      imem_rsp_data  = has_rsp ? mem_word(mem_q[0]) : 32'h0;
      #1;
      redir   = sel && !m_boot;
      exp_req = !m_boot && !sel && ((mem_q.size() + exp_q.size()) < DEPTH);
      check_eq("req_vld", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
      if (imem_req_valid && mem_rdy) req_seen++;
      check_eq("if_vld", 32'(if_valid), 32'(exp_q.size() != 0));
      check_eq("flush", 32'(flush), 32'(m_flush));
      check_eq("misalign", 32'(misalign), 32'(m_mis));
      if (exp_q.size() != 0 && dec_rdy && !redir) begin
         e = exp_q.pop_front();
         check_eq("if_pc", if_pc, e[63:32]);
         check_eq("if_instr", if_instr, e[31:0]);
         if (watch_first) begin
            first_pc    = if_pc;
            watch_first = 1'b0;
         end
      end
      if (has_rsp) begin
         a = mem_q.pop_front();
         if (!redir) begin
            if (m_drop > 0) m_drop--;
            else exp_q.push_back({a, mem_word(a)});
         end
      end
      if (redir) begin
         exp_q.delete();
         m_drop = mem_q.size();
         m_pc   = {tgt[31:2], 2'b00};
      end
      if (exp_req && mem_rdy) begin
         mem_q.push_back(m_pc);
         m_pc += 32'd4;
      end
      m_flush = redir;
      m_mis   = redir && tgt[1];
      m_boot  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset asserted mid-cycle; released at posedge+1 so the next cycle is BOOT
   task automatic do_reset_async();
      #2;
      rst            = 1'b0;
      pc_sel         = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      if_ready       = 1'b0;
      #1;
      check_eq("rst_req_vld", 32'(imem_req_valid), 32'h0);
      check_eq("rst_if_vld", 32'(if_valid), 32'h0);
      check_eq("rst_flush", 32'(flush), 32'h0);
      check_eq("rst_misalign", 32'(misalign), 32'h0);
      check_eq("rst_addr", imem_req_addr, RESET_PC);
      mem_q.delete();
      exp_q.delete();
      m_pc    = RESET_PC;
      m_drop  = 0;
      m_flush = 1'b0;
      m_mis   = 1'b0;
      m_boot  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (mem_q.size() + exp_q.size()) != 0; i++)
         cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      rst            = 1'b0;
      pc_sel         = 1'b0;
      alu_target     = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if_ready       = 1'b0;
      m_pc           = RESET_PC;
      m_drop         = 0;
      m_boot         = 1'b1;
      m_flush        = 1'b0;
      m_mis          = 1'b0;
      req_seen       = 0;
      watch_first    = 1'b0;
      first_pc       = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      do_reset_async();

      // BOOT cycle: a redirect here must be ignored
      cycle(1'b1, 32'h500, 1'b1, 1'b1, 1'b1);
      repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // decode stalled: exactly DEPTH requests may issue
      drain();
      req_seen = 0;
      repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      check_eq("credit_reqs", 32'(req_seen), 32'(DEPTH));
      repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // redirect with three requests in flight
      drain();
      for (int i = 0; i < 10 && mem_q.size() < 3; i++)
         cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
      watch_first = 1'b1;
      repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      check_eq("redir_first_pc", first_pc, 32'h100);

      // redirect coinciding with a response and a buffer pop
      drain();
      repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
      check_eq("redir_buf_empty", 32'(if_valid), 32'h0);
      repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // misaligned target, then PC wrap past 0xFFFF_FFFC
      cycle(1'b1, 32'h202, 1'b1, 1'b1, 1'b1);
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
      repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // back-to-back redirects
      cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 32'h503, 1'b1, 1'b1, 1'b1);
      repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

      // asynchronous reset in the middle of a burst, then restart
      repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      do_reset_async();
      repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
